vm_txn_seq: RTL

- Purchase-transaction sequencer for the vending machine.
- Decodes the active-low one-hot switch bank and the fix key into commands.
- Builds a cart from item code, item price and quantity, collects coins, and dispenses cart lines over a valid/ready handshake.
- Reports change; sits between the switch/up-down-counter front end and the dispenser/display back end.

---
 rtl/vm_pkg.sv | 41 ++++
 rtl/vm_cart_fifo.sv | 57 +++++
 rtl/vm_txn_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// Shared encodings, widths and the cart line record for the vending-machine
// transaction sequencer.
package vm_pkg;

    localparam int CODE_W  = 10;
    localparam int PRICE_W = 17;
    localparam int QTY_W   = 7;
    localparam int PAID_W  = 18;
    localparam int PROD_W  = PRICE_W + QTY_W;
    localparam int SUM_W   = PROD_W + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_SELECT   = 3'b001,
        S_QTY      = 3'b010,
        S_CART     = 3'b011,
        S_PAY      = 3'b100,
        S_DISPENSE = 3'b101,
        S_CHANGE   = 3'b110
    } state_e;

    localparam logic [3:0] SW_CANCEL = 4'b0111;
    localparam logic [3:0] SW_ITEM   = 4'b1011;
    localparam logic [3:0] SW_QTY    = 4'b1101;
    localparam logic [3:0] SW_ADD    = 4'b1110;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [QTY_W-1:0]  qty;
    } cart_line_t;

    function automatic logic [PAID_W-1:0] paid_sat_add(
        input logic [PAID_W-1:0]  a,
        input logic [PRICE_W-1:0] b
    );
        logic [PAID_W:0] s;
        s = {1'b0, a} + {2'b00, b};
        return s[PAID_W] ? {PAID_W{1'b1}} : s[PAID_W-1:0];
    endfunction

endpackage

// File: rtl/vm_cart_fifo.sv
// Cart line FIFO: holds {code, qty} lines in order of addition.
module vm_cart_fifo
    import vm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       clear,
    input  cart_line_t din,
    output logic       full,
    output logic       empty,
    output cart_line_t head
);
    localparam int AW = $clog2(DEPTH);

    cart_line_t mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic        do_push, do_pop;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign head    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clear) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/vm_txn_seq.sv
// Purchase-transaction sequencer: cart build, coin collection, dispense, change.
// Define VM_TIMEOUT_EN to cancel automatically after TIMEOUT_CYC idle cycles.
module vm_txn_seq
    import vm_pkg::*;
#(
    parameter int CART_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         switches,
    input  logic               fix,
    input  logic [CODE_W-1:0]  item_code,
    input  logic [PRICE_W-1:0] item_price,
    input  logic [QTY_W-1:0]   qty,
    input  logic               coin_valid,
    input  logic [PRICE_W-1:0] coin_value,
    output logic               disp_valid,
    input  logic               disp_ready,
    output logic [CODE_W-1:0]  disp_code,
    output logic [QTY_W-1:0]   disp_qty,
    output logic [PRICE_W-1:0] total_sum,
    output logic [PAID_W-1:0]  paid_sum,
    output logic [PAID_W-1:0]  change,
    output logic               change_valid,
    output logic [2:0]         mode,
    output logic               err
);
    state_e              state_q, state_d;
    logic [PRICE_W-1:0]  total_q, total_d;
    logic [PAID_W-1:0]   paid_q, paid_d;
    logic                refund_q, refund_d;
    logic [3:0]          sw_q, sw_p_q;
    logic                fix_q, fix_p_q;

    logic cmd_cancel, cmd_item, cmd_qty, cmd_add, cmd_fix, sw_cmd;
    logic cancel, tmo_hit;
    logic push, pop, clr, full, empty, add_ok;
    cart_line_t head;
    logic [PROD_W-1:0] prod;
    logic [SUM_W-1:0]  sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_q    <= 4'hF;
            sw_p_q  <= 4'hF;
            fix_q   <= 1'b0;
            fix_p_q <= 1'b0;
        end else begin
            sw_q    <= switches;
            sw_p_q  <= sw_q;
            fix_q   <= fix;
            fix_p_q <= fix_q;
        end
    end

    // Commands fire once per change of the registered key code.
    always_comb begin
        cmd_cancel = 1'b0;
        cmd_item   = 1'b0;
        cmd_qty    = 1'b0;
        cmd_add    = 1'b0;
        if (sw_q != sw_p_q) begin
            unique case (1'b1)
                (sw_q == SW_CANCEL): cmd_cancel = 1'b1;
                (sw_q == SW_ITEM):   cmd_item   = 1'b1;
                (sw_q == SW_QTY):    cmd_qty    = 1'b1;
                (sw_q == SW_ADD):    cmd_add    = 1'b1;
                default: ;
            endcase
        end
        sw_cmd  = cmd_cancel | cmd_item | cmd_qty | cmd_add;
        cmd_fix = fix_q & ~fix_p_q & ~sw_cmd;
    end

`ifdef VM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_act;

    assign tmo_act = (state_q == S_SELECT) || (state_q == S_QTY) ||
                     (state_q == S_CART) || (state_q == S_PAY);
    assign tmo_hit = tmo_act && (tmo_q == TW'(TIMEOUT_CYC));

    always_comb begin
        tmo_d = '0;
        if (tmo_act && !tmo_hit && !sw_cmd && !cmd_fix && !coin_valid)
            tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign cancel = cmd_cancel | tmo_hit;
    assign prod   = PROD_W'(item_price) * PROD_W'(qty);
    assign sum    = SUM_W'(total_q) + SUM_W'(prod);
    assign add_ok = (qty != '0) && !full &&
                    (sum <= SUM_W'((1 << PRICE_W) - 1));

    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        paid_d   = paid_q;
        refund_d = refund_q;
        push     = 1'b0;
        pop      = 1'b0;
        clr      = 1'b0;
        err      = 1'b0;
        if (coin_valid) begin
            if (state_q == S_PAY) paid_d = paid_sat_add(paid_q, coin_value);
            else                  err    = 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (cmd_item) state_d = S_SELECT;
            end
            S_SELECT, S_QTY, S_CART: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    total_d = '0;
                    clr     = 1'b1;
                end else if (cmd_item) begin
                    state_d = S_SELECT;
                end else if (cmd_qty) begin
                    state_d = S_QTY;
                end else if (cmd_add && state_q != S_CART) begin
                    if (add_ok) begin
                        state_d = S_CART;
                        total_d = sum[PRICE_W-1:0];
                        push    = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end else if (cmd_fix && state_q == S_CART) begin
                    if (!empty) state_d = S_PAY;
                    else        err     = 1'b1;
                end
            end
            S_PAY: begin
                if (cancel) begin
                    state_d  = S_CHANGE;
                    refund_d = 1'b1;
                end else if (paid_q >= PAID_W'(total_q)) begin
                    state_d = S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                pop = !empty && disp_ready;
                if (empty) state_d = S_CHANGE;
            end
            S_CHANGE: begin
                state_d  = S_IDLE;
                total_d  = '0;
                paid_d   = '0;
                refund_d = 1'b0;
                clr      = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            total_q  <= '0;
            paid_q   <= '0;
            refund_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            paid_q   <= paid_d;
            refund_q <= refund_d;
        end
    end

    vm_cart_fifo #(.DEPTH(CART_DEPTH)) u_cart (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (clr),
        .din   ({item_code, qty}),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_comb begin
        change = '0;
        if (state_q == S_CHANGE)
            change = refund_q ? paid_q : paid_q - PAID_W'(total_q);
    end

    assign change_valid = (state_q == S_CHANGE);
    assign disp_valid   = (state_q == S_DISPENSE) && !empty;
    assign disp_code    = head.code;
    assign disp_qty     = head.qty;
    assign total_sum    = total_q;
    assign paid_sum     = paid_q;
    assign mode         = state_q;

endmodule
